// File: rtl/syn_update_sequencer.sv
// Training-phase weight-update sequencer: read-modify-write sweep over the synaptic SRAM.
// Optional macro SKIP_ZERO_PRE_EN: check each row's pre-neuron spike count first and skip silent rows.
module syn_update_sequencer #(
   parameter int N_PRE  = 784,
   parameter int N_POST = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IS_TRAIN,
   input  logic        SPI_GATE_ACTIVITY_sync,
   input  logic        START,
   input  logic [7:0]  PRE_NEUR_S_CNT,
   output logic [9:0]  PRE_NEUR_ADDR,
   output logic        CTRL_SYNARRAY_CS,
   output logic        CTRL_SYNARRAY_WE,
   output logic [15:0] CTRL_SYNARRAY_ADDR,
   output logic [9:0]  CTRL_POST_NEURON_ADDRESS,
   output logic        CTRL_TREF_EVENT,
   output logic        BUSY,
   output logic        DONE
);
   localparam int WPR = (N_POST + 3) / 4;
   localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;
   localparam logic [15:0]   LAST_ADDR = 16'(N_PRE * WPR - 1);
   localparam logic [WW-1:0] LAST_WORD = WW'(WPR - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SYN_RD = 3'd1;
   localparam logic [2:0] S_SYN_WR = 3'd2;
   localparam logic [2:0] S_PAUSE  = 3'd3;
   localparam logic [2:0] S_FIN    = 3'd4;
`ifdef SKIP_ZERO_PRE_EN
   localparam logic [2:0] S_CNT_RD    = 3'd5;
   localparam logic [2:0] S_CNT_CHK   = 3'd6;
   localparam logic [2:0] S_ROW_ENTRY = S_CNT_RD;
   localparam logic [9:0] LAST_ROW    = 10'(N_PRE - 1);
`else
   localparam logic [2:0] S_ROW_ENTRY = S_SYN_RD;
   logic unused_cnt;
   assign unused_cnt = ^PRE_NEUR_S_CNT;
`endif

   generate
      if (N_PRE * WPR > 65536 || N_PRE > 1024) begin : g_param_check
         $error("syn_update_sequencer: N_PRE*WPR must be <= 65536 and N_PRE <= 1024");
      end
   endgenerate

   logic [2:0]    state_q, state_d;
   logic [9:0]    row_q, row_d;
   logic [WW-1:0] word_q, word_d;
   logic [15:0]   addr_q, addr_d;
   logic          cs_q, cs_d;
   logic          we_q, we_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [2:0]    after_wr;

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      word_d   = word_q;
      addr_d   = addr_q;
      after_wr = S_SYN_RD;
      case (state_q)
         S_IDLE: begin
            if (START && IS_TRAIN && !SPI_GATE_ACTIVITY_sync) begin
               row_d   = '0;
               word_d  = '0;
               addr_d  = '0;
               state_d = S_ROW_ENTRY;
            end
         end
         S_SYN_RD: state_d = S_SYN_WR;
         S_SYN_WR: begin
            // Counters stop on the final word so the address never runs past the array.
            if (addr_q == LAST_ADDR) begin
               state_d = S_FIN;
            end else begin
               addr_d = addr_q + 16'd1;
               if (word_q == LAST_WORD) begin
                  word_d   = '0;
                  row_d    = row_q + 10'd1;
                  after_wr = S_ROW_ENTRY;
               end else begin
                  word_d = word_q + WW'(1);
               end
               state_d = SPI_GATE_ACTIVITY_sync ? S_PAUSE : after_wr;
            end
         end
         S_PAUSE: begin
            // A pause after a row's last word must resume with that new row's entry state.
            if (!SPI_GATE_ACTIVITY_sync)
               state_d = (word_q == '0) ? S_ROW_ENTRY : S_SYN_RD;
         end
         S_FIN: state_d = S_IDLE;
`ifdef SKIP_ZERO_PRE_EN
         S_CNT_RD: state_d = S_CNT_CHK;
         S_CNT_CHK: begin
            if (PRE_NEUR_S_CNT != 8'd0) begin
               state_d = S_SYN_RD;
            end else if (row_q == LAST_ROW) begin
               state_d = S_FIN;
            end else begin
               row_d   = row_q + 10'd1;
               addr_d  = addr_q + 16'(WPR);
               state_d = S_CNT_RD;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      cs_d   = (state_d == S_SYN_RD) || (state_d == S_SYN_WR);
      we_d   = (state_d == S_SYN_WR);
      busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
      done_d = (state_d == S_FIN);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         cs_q    <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign PRE_NEUR_ADDR            = row_q;
   assign CTRL_SYNARRAY_CS         = cs_q;
   assign CTRL_SYNARRAY_WE         = we_q;
   assign CTRL_TREF_EVENT          = we_q;
   assign CTRL_SYNARRAY_ADDR       = addr_q;
   assign CTRL_POST_NEURON_ADDRESS = 10'({word_q, 2'b00});
   assign BUSY                     = busy_q;
   assign DONE                     = done_q;

endmodule
